// File: rtl/cmp_chk_pkg.sv
// Shared types and defaults for the comparator response checker.
// Holds the run-state enum and default operand/counter widths.
package cmp_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/cmp_ref_model.sv
// Golden unsigned magnitude comparator.
// Produces the one-hot response a correct comparator must give.
module cmp_ref_model
    import cmp_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             exp_g,
    output logic             exp_eq,
    output logic             exp_l
);

    // Unsigned relational compare of the applied operands
    always_comb begin
        exp_g  = (a > b);
        exp_eq = (a == b);
        exp_l  = (a < b);
    end

endmodule

// File: rtl/comparator_response_checker.sv
// Checks a comparator's {g,eq,l} answers against a reference model.
// Counts passes/fails over a run and captures the first failure.
module comparator_response_checker
    import cmp_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             g,
    input  logic             eq,
    input  logic             l,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic             ff_valid,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic [2:0]       ff_res
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             ffv_q, ffv_d;
    logic [WIDTH-1:0] ffa_q, ffa_d;
    logic [WIDTH-1:0] ffb_q, ffb_d;
    logic [2:0]       ffr_q, ffr_d;

    logic       exp_g, exp_eq, exp_l;
    logic [2:0] resp;
    logic       hit;

    cmp_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a      (a),
        .b      (b),
        .exp_g  (exp_g),
        .exp_eq (exp_eq),
        .exp_l  (exp_l)
    );

    // Exact match against the golden one-hot answer
    always_comb begin
        resp = {g, eq, l};
        hit  = (resp == {exp_g, exp_eq, exp_l});
    end

    // Next-state: run control, counters and first-fail capture
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        acc_d   = acc_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ffv_d   = ffv_q;
        ffa_d   = ffa_q;
        ffb_d   = ffb_q;
        ffr_d   = ffr_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_d   = num_vec;
                    acc_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    ffv_d   = 1'b0;
                    ffa_d   = '0;
                    ffb_d   = '0;
                    ffr_d   = '0;
                    state_d = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    acc_d = acc_q + 1'b1;
                    if (hit) begin
                        if (pass_q != CNT_MAX)
                            pass_d = pass_q + 1'b1;
                    end else begin
                        if (fail_q != CNT_MAX)
                            fail_d = fail_q + 1'b1;
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffa_d = a;
                            ffb_d = b;
                            ffr_d = resp;
                        end
                    end
                    if (acc_d == num_q)
                        state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            acc_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ffv_q   <= 1'b0;
            ffa_q   <= '0;
            ffb_q   <= '0;
            ffr_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            ffa_q   <= ffa_d;
            ffb_q   <= ffb_d;
            ffr_q   <= ffr_d;
        end
    end

    // Status outputs decoded straight from flops
    always_comb begin
        in_ready = (state_q == RUN);
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        all_pass = (state_q == DONE) && (fail_q == '0);
        pass_cnt = pass_q;
        fail_cnt = fail_q;
        ff_valid = ffv_q;
        ff_a     = ffa_q;
        ff_b     = ffb_q;
        ff_res   = ffr_q;
    end

endmodule

// File: tb/tb_comparator_response_checker.sv
// Directed bench for comparator_response_checker.
// A behavioural model is compared every cycle; literals pin key results.
module tb_comparator_response_checker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vec = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             g = 1'b0;
    logic             eq = 1'b0;
    logic             l = 1'b0;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             busy;
    logic             done;
    logic             all_pass;
    logic             ff_valid;
    logic [WIDTH-1:0] ff_a;
    logic [WIDTH-1:0] ff_b;
    logic [2:0]       ff_res;

    comparator_response_checker #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_vec  (num_vec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .g        (g),
        .eq       (eq),
        .l        (l),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .busy     (busy),
        .done     (done),
        .all_pass (all_pass),
        .ff_valid (ff_valid),
        .ff_a     (ff_a),
        .ff_b     (ff_b),
        .ff_res   (ff_res)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] good(int av, int bv);
        logic [2:0] r;
        r = {av > bv, av == bv, av < bv};
        return r;
    endfunction

    // Behavioural model: phase 0=idle 1=running 2=finished
    int m_phase = 0;
    int m_target = 0;
    int m_seen = 0;
    int m_pass = 0;
    int m_fail = 0;
    int m_ffv = 0;
    int m_ffa = 0;
    int m_ffb = 0;
    int m_ffr = 0;

    task automatic model_step();
        int av, bv, r, want, lim;
        lim = (1 << CNT_W) - 1;
        if (!rst_n) begin
            m_phase = 0; m_target = 0; m_seen = 0;
            m_pass = 0; m_fail = 0;
            m_ffv = 0; m_ffa = 0; m_ffb = 0; m_ffr = 0;
        end else if (m_phase != 1 && start) begin
            m_target = int'(num_vec);
            m_seen = 0; m_pass = 0; m_fail = 0;
            m_ffv = 0; m_ffa = 0; m_ffb = 0; m_ffr = 0;
            m_phase = (m_target == 0) ? 2 : 1;
        end else if (m_phase == 1 && in_valid) begin
            av = int'(a);
            bv = int'(b);
            r = int'({g, eq, l});
            want = (av > bv) ? 4 : ((av == bv) ? 2 : 1);
            if (r == want) begin
                if (m_pass < lim) m_pass++;
            end else begin
                if (m_fail < lim) m_fail++;
                if (m_ffv == 0) begin
                    m_ffv = 1; m_ffa = av; m_ffb = bv; m_ffr = r;
                end
            end
            m_seen++;
            if (m_seen == m_target) m_phase = 2;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("all_pass", 32'(all_pass), 32'(m_phase == 2 && m_fail == 0));
        chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
        chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
        chk("ff_valid", 32'(ff_valid), 32'(m_ffv));
        chk("ff_a", 32'(ff_a), 32'(m_ffa));
        chk("ff_b", 32'(ff_b), 32'(m_ffb));
        chk("ff_res", 32'(ff_res), 32'(m_ffr));
    end

    task automatic send(int av, int bv, logic [2:0] r);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        a = 4'(av);
        b = 4'(bv);
        {g, eq, l} = r;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_start(int n);
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        num_vec = 8'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic all_zero(string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 0);
        chk({tag, "_pass"}, 32'(pass_cnt), 0);
        chk({tag, "_fail"}, 32'(fail_cnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_allp"}, 32'(all_pass), 0);
        chk({tag, "_ffv"}, 32'(ff_valid), 0);
        chk({tag, "_ffa"}, 32'(ff_a), 0);
        chk({tag, "_ffb"}, 32'(ff_b), 0);
        chk({tag, "_ffr"}, 32'(ff_res), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        all_zero("rst");
        rst_n = 1'b1;

        // Exhaustive pass run, 30 vectors
        do_start(30);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 6; j++)
                send(i, j, good(i, j));
        idle();
        chk("ex_pass", 32'(pass_cnt), 30);
        chk("ex_fail", 32'(fail_cnt), 0);
        chk("ex_done", 32'(done), 1);
        chk("ex_allp", 32'(all_pass), 1);
        chk("ex_ffv", 32'(ff_valid), 0);

        // Injected fault on the 7th of 10 samples
        do_start(10);
        for (int i = 0; i < 10; i++) begin
            if (i == 6) send(3, 3, 3'b100);
            else send(i, 9 - i, good(i, 9 - i));
        end
        idle();
        chk("inj_fail", 32'(fail_cnt), 1);
        chk("inj_pass", 32'(pass_cnt), 9);
        chk("inj_ffa", 32'(ff_a), 3);
        chk("inj_ffb", 32'(ff_b), 3);
        chk("inj_ffr", 32'(ff_res), 32'b100);
        chk("inj_allp", 32'(all_pass), 0);

        // Non-one-hot answer then a second failure
        do_start(3);
        send(5, 2, 3'b110);
        send(1, 7, 3'b000);
        send(4, 4, 3'b010);
        idle();
        chk("noh_fail", 32'(fail_cnt), 2);
        chk("noh_pass", 32'(pass_cnt), 1);
        chk("noh_ffa", 32'(ff_a), 5);
        chk("noh_ffb", 32'(ff_b), 2);
        chk("noh_ffr", 32'(ff_res), 32'b110);

        // Empty run, then start ignored mid-run
        do_start(0);
        chk("z_done", 32'(done), 1);
        chk("z_allp", 32'(all_pass), 1);
        chk("z_rdy0", 32'(in_ready), 0);
        idle();
        chk("z_rdy1", 32'(in_ready), 0);
        do_start(3);
        send(1, 2, good(1, 2));
        do_start(0);
        chk("st_pass", 32'(pass_cnt), 1);
        chk("st_busy", 32'(busy), 1);
        send(2, 1, good(2, 1));
        send(6, 6, good(6, 6));
        idle();
        chk("st_pass3", 32'(pass_cnt), 3);
        chk("st_done", 32'(done), 1);

        // Gapped valid and back-pressure
        do_start(4);
        send(1, 1, good(1, 1));
        idle();
        send(8, 3, good(8, 3));
        idle();
        send(0, 15, good(0, 15));
        send(15, 0, good(15, 0));
        idle();
        chk("gap_rdy", 32'(in_ready), 0);
        chk("gap_done", 32'(done), 1);
        send(2, 2, 3'b001);
        idle();
        chk("gap_pass", 32'(pass_cnt), 4);
        chk("gap_fail", 32'(fail_cnt), 0);

        // Reset in the middle of a run
        do_start(8);
        send(1, 0, good(1, 0));
        send(2, 0, 3'b000);
        send(3, 0, good(3, 0));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        all_zero("mid");
        do_start(2);
        send(4, 5, good(4, 5));
        send(9, 9, good(9, 9));
        idle();
        chk("rr_pass", 32'(pass_cnt), 2);
        chk("rr_done", 32'(done), 1);
        chk("rr_allp", 32'(all_pass), 1);

        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comparator_response_checker.md
COMPARATOR_RESPONSE_CHECKER -- requirements
Module: comparator_response_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width of a and b.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the vector-count and result counters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port start, input, 1 bit: begins a check run; honoured only in IDLE or DONE.
REQ-006 The block SHALL have port num_vec, input, CNT_W bits: the number of vectors in the run, latched on an accepted start.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a, b, g, eq and l carry a sample.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 The block SHALL have ports a and b, input, WIDTH bits each: the operands applied to the comparator under test.
REQ-010 The block SHALL have ports g, eq and l, input, 1 bit each: the comparator under test's greater, equal and less outputs.
REQ-011 The block SHALL have ports pass_cnt and fail_cnt, output, CNT_W bits each: passing and failing sample counts.
REQ-012 The block SHALL have ports busy, done and all_pass, output, 1 bit each: run active, run complete, and run complete with zero failures.
REQ-013 The block SHALL have ports ff_valid (1 bit), ff_a (WIDTH), ff_b (WIDTH) and ff_res (3 bits, {g,eq,l}), all outputs: the first failing sample captured.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, RUN and DONE; busy=1 only in RUN, and done=1 only in DONE.
REQ-015 In IDLE or DONE, start=1 SHALL latch num_vec, clear pass_cnt, fail_cnt, ff_* and the accepted-sample counter, and enter RUN on the next edge, or enter DONE if num_vec=0.
REQ-016 start SHALL be ignored in RUN.
REQ-017 in_ready SHALL equal 1 exactly when the state is RUN; a sample is accepted on an edge where in_valid and in_ready are both 1.
REQ-018 The expected result SHALL be g=(a>b), eq=(a==b), l=(a<b), compared as unsigned values.
REQ-019 An accepted sample SHALL pass only if {g,eq,l} equals the expected result exactly; any non-one-hot response is a failure.
REQ-020 pass_cnt or fail_cnt SHALL increment on the accepting edge, so the update is visible one cycle after acceptance, and SHALL saturate at 2^CNT_W-1.
REQ-021 On the first failure of a run, the block SHALL capture a, b and {g,eq,l} into ff_* and set ff_valid=1; later failures SHALL NOT overwrite the capture.
REQ-022 When the accepted count reaches the latched num_vec, the FSM SHALL enter DONE on that same edge, and in_ready SHALL be 0 in the following cycle.
REQ-023 In DONE, all_pass SHALL be 1 iff fail_cnt=0; the counters and ff_* SHALL hold until the next accepted start.
REQ-024 Samples presented while in_ready=0 SHALL be ignored without any state change.

Reset
REQ-025 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE and every output SHALL be driven to 0: in_ready, pass_cnt, fail_cnt, busy, done, all_pass, ff_valid, ff_a, ff_b and ff_res.
REQ-026 Reset in the middle of a run SHALL abandon the run with no partial results retained; reset SHALL take priority over start and over sample acceptance.

Structure
REQ-027 A shared package cmp_chk_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH and CNT_W constants.
REQ-028 The expected-result logic SHALL be a purely combinational sub-module cmp_ref_model (a, b -> exp_g, exp_eq, exp_l), instantiated once.

Verification
REQ-029 The bench SHALL cover an exhaustive pass run: num_vec=30, a in 0..4 x b in 0..5, correct responses -> pass_cnt=30, fail_cnt=0, done=1, all_pass=1, ff_valid=0.
REQ-030 The bench SHALL cover an injected fault: sample 7 is a=3, b=3 answered {1,0,0}, num_vec=10 -> fail_cnt=1, pass_cnt=9, ff_a=3, ff_b=3, ff_res=3'b100, all_pass=0.
REQ-031 The bench SHALL cover a non-one-hot response: a=5, b=2 answered {1,1,0} -> counted as a failure, and a second failure does not change ff_*.
REQ-032 The bench SHALL cover num_vec=0: start -> DONE next cycle with all_pass=1 and in_ready never 1; a start pulse during RUN leaves the counts unchanged.
REQ-033 The bench SHALL cover gapped valid and back-pressure: in_valid toggles, num_vec=4 -> exactly 4 samples accepted, in_ready=0 the cycle after the 4th, and a 5th valid sample is ignored.
REQ-034 The bench SHALL cover reset mid-run: rst_n=0 for 1 cycle after 3 of 8 samples -> IDLE with all outputs 0; a new start with num_vec=2 then completes with pass_cnt=2.
